// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle control unit: state encoding,
// opcode values, control-bus bit positions and the opcode legality check.
package cu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_J     = 6'h02;

    localparam int CB_PC_WRITE   = 0;
    localparam int CB_IR_WRITE   = 1;
    localparam int CB_MEM_READ   = 2;
    localparam int CB_MEM_WRITE  = 3;
    localparam int CB_REG_WRITE  = 4;
    localparam int CB_ALU_SRC    = 5;
    localparam int CB_MEM_TO_REG = 6;
    localparam int CB_BRANCH     = 7;
    localparam int CB_COUNT      = 8;

    typedef struct packed {
        logic rtype;
        logic addi;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic illegal;
    } op_class_t;

    function automatic logic is_legal(input logic [5:0] opc);
        case (opc)
            OPC_RTYPE, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_J: is_legal = 1'b1;
            default:                                            is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cu_multicycle_if.sv
// Instruction-side / datapath-side signal bundle of the multi-cycle control unit.
interface cu_multicycle_if #(
    parameter int OPC_W  = 6,
    parameter int CTRL_W = 8
);
    logic [OPC_W-1:0]  opCode;
    logic              instr_valid;
    logic              mem_ready;
    logic [CTRL_W-1:0] control_signals;
    logic [2:0]        cu_state;
    logic              busy;
    logic              instr_done;
    logic              fault;

    modport master (
        output opCode, instr_valid, mem_ready,
        input  control_signals, cu_state, busy, instr_done, fault
    );

    modport slave (
        input  opCode, instr_valid, mem_ready,
        output control_signals, cu_state, busy, instr_done, fault
    );
endinterface

// File: rtl/cu_opdecode.sv
// Combinational opcode classifier: latched opcode -> one-hot instruction class.
module cu_opdecode
    import cu_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opc_q,
    output op_class_t        op_class
);

    logic       upper_zero;
    logic [5:0] opc_lo;

    assign opc_lo = opc_q[5:0];

    // Any set bit above the 6-bit opcode field makes the instruction illegal.
    generate
        if (OPC_W > 6) begin : g_upper
            assign upper_zero = (opc_q[OPC_W-1:6] == '0);
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        op_class         = '0;
        op_class.rtype   = upper_zero && (opc_lo == OPC_RTYPE);
        op_class.addi    = upper_zero && (opc_lo == OPC_ADDI);
        op_class.lw      = upper_zero && (opc_lo == OPC_LW);
        op_class.sw      = upper_zero && (opc_lo == OPC_SW);
        op_class.beq     = upper_zero && (opc_lo == OPC_BEQ);
        op_class.j       = upper_zero && (opc_lo == OPC_J);
        op_class.illegal = !(upper_zero && is_legal(opc_lo));
    end

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory
// handshake, illegal-opcode trap and memory-timeout trap.
module cu_multicycle
    import cu_pkg::*;
#(
    parameter int OPC_W       = 6,
    parameter int CTRL_W      = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    cu_multicycle_if.slave    bus
);

    state_t           state_reg, state_next;
    logic [OPC_W-1:0] opc_reg, opc_next;
    logic [7:0]       tmo_cnt_reg, tmo_cnt_next;
    logic [CB_COUNT-1:0] ctrl;
    logic             done;
    logic             mem_wait;
    logic             tmo_hit;
    op_class_t        op_class;

    cu_opdecode #(.OPC_W(OPC_W)) u_opdecode (
        .opc_q    (opc_reg),
        .op_class (op_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            opc_reg     <= '0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            opc_reg     <= opc_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    assign mem_wait = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !bus.mem_ready;
    assign tmo_hit  = mem_wait && (tmo_cnt_reg == 8'(MEM_TIMEOUT));

    always_comb begin
        state_next = state_reg;
        opc_next   = opc_reg;
        ctrl       = '0;
        done       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.instr_valid) state_next = S_FETCH;
            end
            S_FETCH: begin
                ctrl[CB_MEM_READ] = 1'b1;
                if (bus.mem_ready) begin
                    ctrl[CB_IR_WRITE] = 1'b1;
                    ctrl[CB_PC_WRITE] = 1'b1;
                    opc_next          = bus.opCode;
                    state_next        = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                state_next = op_class.illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                if (op_class.rtype) begin
                    state_next = S_WB;
                end else if (op_class.addi) begin
                    ctrl[CB_ALU_SRC] = 1'b1;
                    state_next       = S_WB;
                end else if (op_class.lw || op_class.sw) begin
                    ctrl[CB_ALU_SRC] = 1'b1;
                    state_next       = S_MEM;
                end else if (op_class.beq) begin
                    ctrl[CB_BRANCH] = 1'b1;
                    done            = 1'b1;
                end else if (op_class.j) begin
                    ctrl[CB_PC_WRITE] = 1'b1;
                    done              = 1'b1;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_MEM: begin
                if (op_class.lw) begin
                    ctrl[CB_MEM_READ] = 1'b1;
                    if (bus.mem_ready) state_next = S_WB;
                end else if (op_class.sw) begin
                    ctrl[CB_MEM_WRITE] = 1'b1;
                    if (bus.mem_ready) done = 1'b1;
                end else begin
                    state_next = S_TRAP;
                end
                if (tmo_hit) state_next = S_TRAP;
            end
            S_WB: begin
                ctrl[CB_REG_WRITE]  = 1'b1;
                ctrl[CB_MEM_TO_REG] = op_class.lw;
                done                = 1'b1;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase

        // Final cycle of an instruction: chain straight into the next fetch if requested.
        if (done) state_next = bus.instr_valid ? S_FETCH : S_IDLE;
    end

    // Counter only runs while a memory access keeps waiting in the same state.
    always_comb begin
        tmo_cnt_next = '0;
        if (mem_wait && (state_next == state_reg)) tmo_cnt_next = tmo_cnt_reg + 8'd1;
    end

    generate
        for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl
            if (gi < CB_COUNT) begin : g_used
                assign bus.control_signals[gi] = ctrl[gi];
            end else begin : g_zero
                assign bus.control_signals[gi] = 1'b0;
            end
        end
    endgenerate

    assign bus.cu_state   = state_reg;
    assign bus.busy       = (state_reg != S_IDLE) && (state_reg != S_TRAP);
    assign bus.instr_done = done;
    assign bus.fault      = (state_reg == S_TRAP);

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed bench for cu_multicycle: per-cycle state/control/done checks against
// hand-computed values, with MEM_TIMEOUT=3 to reach the timeout boundary quickly.
module tb_cu_multicycle;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    cu_multicycle_if #(.OPC_W(6), .CTRL_W(8)) bus ();

    cu_multicycle #(.OPC_W(6), .CTRL_W(8), .MEM_TIMEOUT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check the current cycle (inputs already applied), then advance one clock.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] ctl, input logic dn);
        #1;
        chk({tag, ".state"}, 32'(bus.cu_state), 32'(st));
        chk({tag, ".ctrl"},  32'(bus.control_signals), 32'(ctl));
        chk({tag, ".done"},  32'(bus.instr_done), 32'(dn));
        $display("cycle %-10s state=%0d ctrl=0x%02h done=%0b busy=%0b fault=%0b",
                 tag, bus.cu_state, bus.control_signals, bus.instr_done, bus.busy, bus.fault);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.opCode      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.opCode      = '0;

        // 1: reset state
        do_reset();
        #1;
        chk("rst.state", 32'(bus.cu_state), 32'd0);
        chk("rst.ctrl",  32'(bus.control_signals), 32'h00);
        chk("rst.fault", 32'(bus.fault), 32'd0);
        chk("rst.busy",  32'(bus.busy), 32'd0);

        // 2: RTYPE with memory always ready
        bus.opCode = 6'h00; bus.instr_valid = 1'b1; bus.mem_ready = 1'b1;
        cyc("rt.idle", 3'd0, 8'h00, 1'b0);
        bus.instr_valid = 1'b0;
        chk("rt.busy", 32'(bus.busy), 32'd1);
        cyc("rt.fetch", 3'd1, 8'h07, 1'b0);
        cyc("rt.decode", 3'd2, 8'h00, 1'b0);
        cyc("rt.exec", 3'd3, 8'h00, 1'b0);
        cyc("rt.wb", 3'd5, 8'h10, 1'b1);
        cyc("rt.after", 3'd0, 8'h00, 1'b0);

        // 3: LW, memory stalls for 3 MEM cycles (ready exactly at the timeout count)
        bus.opCode = 6'h23; bus.instr_valid = 1'b1; bus.mem_ready = 1'b1;
        cyc("lw.idle", 3'd0, 8'h00, 1'b0);
        bus.instr_valid = 1'b0;
        cyc("lw.fetch", 3'd1, 8'h07, 1'b0);
        cyc("lw.decode", 3'd2, 8'h00, 1'b0);
        cyc("lw.exec", 3'd3, 8'h20, 1'b0);
        bus.mem_ready = 1'b0;
        cyc("lw.mem0", 3'd4, 8'h04, 1'b0);
        cyc("lw.mem1", 3'd4, 8'h04, 1'b0);
        cyc("lw.mem2", 3'd4, 8'h04, 1'b0);
        bus.mem_ready = 1'b1;
        cyc("lw.mem3", 3'd4, 8'h04, 1'b0);
        cyc("lw.wb", 3'd5, 8'h50, 1'b1);
        cyc("lw.after", 3'd0, 8'h00, 1'b0);

        // 5b: ADDI, fetch ready on the 4th cycle wins over the timeout
        bus.opCode = 6'h08; bus.instr_valid = 1'b1; bus.mem_ready = 1'b0;
        cyc("ad.idle", 3'd0, 8'h00, 1'b0);
        bus.instr_valid = 1'b0;
        cyc("ad.fetch0", 3'd1, 8'h04, 1'b0);
        cyc("ad.fetch1", 3'd1, 8'h04, 1'b0);
        cyc("ad.fetch2", 3'd1, 8'h04, 1'b0);
        bus.mem_ready = 1'b1;
        cyc("ad.fetch3", 3'd1, 8'h07, 1'b0);
        cyc("ad.decode", 3'd2, 8'h00, 1'b0);
        cyc("ad.exec", 3'd3, 8'h20, 1'b0);
        cyc("ad.wb", 3'd5, 8'h10, 1'b1);
        cyc("ad.after", 3'd0, 8'h00, 1'b0);

        // 6: BEQ then SW back to back, reset during SW MEM
        bus.opCode = 6'h04; bus.instr_valid = 1'b1; bus.mem_ready = 1'b1;
        cyc("bs.idle", 3'd0, 8'h00, 1'b0);
        cyc("bs.fetch", 3'd1, 8'h07, 1'b0);
        bus.opCode = 6'h2B;
        cyc("bs.decode", 3'd2, 8'h00, 1'b0);
        cyc("bs.beqexec", 3'd3, 8'h80, 1'b1);
        cyc("bs.swfetch", 3'd1, 8'h07, 1'b0);
        bus.instr_valid = 1'b0;
        cyc("bs.swdec", 3'd2, 8'h00, 1'b0);
        cyc("bs.swexec", 3'd3, 8'h20, 1'b0);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        cyc("bs.swmem", 3'd4, 8'h08, 1'b0);
        rst = 1'b0;
        cyc("bs.aborted", 3'd0, 8'h00, 1'b0);

        // 4: illegal opcode traps; instr_valid ignored afterwards
        bus.opCode = 6'h3F; bus.instr_valid = 1'b1; bus.mem_ready = 1'b1;
        cyc("il.idle", 3'd0, 8'h00, 1'b0);
        cyc("il.fetch", 3'd1, 8'h07, 1'b0);
        cyc("il.decode", 3'd2, 8'h00, 1'b0);
        chk("il.fault0", 32'(bus.fault), 32'd1);
        chk("il.busy0", 32'(bus.busy), 32'd0);
        cyc("il.trap0", 3'd7, 8'h00, 1'b0);
        cyc("il.trap1", 3'd7, 8'h00, 1'b0);
        cyc("il.trap2", 3'd7, 8'h00, 1'b0);
        chk("il.fault1", 32'(bus.fault), 32'd1);
        do_reset();
        #1;
        chk("il.clrfault", 32'(bus.fault), 32'd0);
        chk("il.clrstate", 32'(bus.cu_state), 32'd0);

        // 5a: fetch never ready -> trap after 4 FETCH cycles
        bus.opCode = 6'h00; bus.instr_valid = 1'b1; bus.mem_ready = 1'b0;
        cyc("to.idle", 3'd0, 8'h00, 1'b0);
        bus.instr_valid = 1'b0;
        cyc("to.fetch0", 3'd1, 8'h04, 1'b0);
        cyc("to.fetch1", 3'd1, 8'h04, 1'b0);
        cyc("to.fetch2", 3'd1, 8'h04, 1'b0);
        cyc("to.fetch3", 3'd1, 8'h04, 1'b0);
        chk("to.fault", 32'(bus.fault), 32'd1);
        bus.mem_ready = 1'b1;
        cyc("to.trap0", 3'd7, 8'h00, 1'b0);
        cyc("to.trap1", 3'd7, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
